mips_register_file: RTL and testbench

- 32-entry general-purpose register file for the single-cycle/pipelined MIPS core.
- Sits directly downstream of the 5-bit destination-register select mux (rt/rd choice). That mux output drives wr_addr here.
- Provides two combinational read ports (rs, rt) for the decode/ALU stage and one clocked write port for write-back.
- $zero is hardwired and $sp has a configurable reset value.

---
 rtl/mips_register_file_if.sv | 26 ++
 rtl/mips_register_file.sv | 75 +++++++
 tb/tb_mips_register_file.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_register_file_if.sv
// Bus between the MIPS core datapath and the 32-entry register file:
// two combinational read ports, one write-back port and write status.
interface mips_register_file_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic [15:0]       write_count;

  modport master (
    output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data,
    input  rd_data_a, rd_data_b, wr_ack, write_count
  );

  modport slave (
    input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data,
    output rd_data_a, rd_data_b, wr_ack, write_count
  );
endinterface

// File: rtl/mips_register_file.sv
// 32-entry MIPS register file: hardwired $zero, resettable $sp, two
// combinational read ports with optional write forwarding, one write port.
module mips_register_file #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 5,
  parameter int                SP_INDEX = 29,
  parameter logic [DATA_W-1:0] SP_RESET = 32'h0000_3FFC,
  parameter int                BYPASS   = 1
) (
  input logic                 clk,
  input logic                 reset_n,
  mips_register_file_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic              r_wr_ack;
  logic [15:0]       r_write_count;
  logic              w_commit;
  logic [DATA_W-1:0] w_rd_data_a;
  logic [DATA_W-1:0] w_rd_data_b;

  // Writes to $zero are dropped entirely, so they never count as commits.
  assign w_commit = bus.wr_en && (bus.wr_addr != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= (i == SP_INDEX) ? SP_RESET : '0;
      end
    end else if (w_commit) begin
      r_regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ack      <= 1'b0;
      r_write_count <= '0;
    end else begin
      r_wr_ack <= w_commit;
      if (w_commit && (r_write_count != 16'hFFFF)) begin
        r_write_count <= r_write_count + 16'd1;
      end
    end
  end

  // Forwarding lets a reader in the write-back cycle see the incoming value.
  always_comb begin
    w_rd_data_a = '0;
    if (bus.rd_addr_a != '0) begin
      if ((BYPASS != 0) && bus.wr_en && (bus.wr_addr == bus.rd_addr_a)) begin
        w_rd_data_a = bus.wr_data;
      end else begin
        w_rd_data_a = r_regs[bus.rd_addr_a];
      end
    end
  end

  always_comb begin
    w_rd_data_b = '0;
    if (bus.rd_addr_b != '0) begin
      if ((BYPASS != 0) && bus.wr_en && (bus.wr_addr == bus.rd_addr_b)) begin
        w_rd_data_b = bus.wr_data;
      end else begin
        w_rd_data_b = r_regs[bus.rd_addr_b];
      end
    end
  end

  assign bus.rd_data_a   = w_rd_data_a;
  assign bus.rd_data_b   = w_rd_data_b;
  assign bus.wr_ack      = r_wr_ack;
  assign bus.write_count = r_write_count;
endmodule

// File: tb/tb_mips_register_file.sv
// Self-checking bench: drives a forwarding and a non-forwarding register
// file with identical stimulus and compares both against a reference model.
module tb_mips_register_file;
  logic        clk;
  logic        resetN;
  logic [4:0]  rdAddrA;
  logic [4:0]  rdAddrB;
  logic        wrEn;
  logic [4:0]  wrAddr;
  logic [31:0] wrData;

  int checks;
  int failures;

  logic [31:0] model [32];
  int          modelCount;
  bit          modelAck;

  mips_register_file_if #(.DATA_W(32), .ADDR_W(5)) busByp ();
  mips_register_file_if #(.DATA_W(32), .ADDR_W(5)) busNoByp ();

  assign busByp.rd_addr_a   = rdAddrA;
  assign busByp.rd_addr_b   = rdAddrB;
  assign busByp.wr_en       = wrEn;
  assign busByp.wr_addr     = wrAddr;
  assign busByp.wr_data     = wrData;
  assign busNoByp.rd_addr_a = rdAddrA;
  assign busNoByp.rd_addr_b = rdAddrB;
  assign busNoByp.wr_en     = wrEn;
  assign busNoByp.wr_addr   = wrAddr;
  assign busNoByp.wr_data   = wrData;

  mips_register_file #(.BYPASS(1)) dutByp (
    .clk     (clk),
    .reset_n (resetN),
    .bus     (busByp)
  );

  mips_register_file #(.BYPASS(0)) dutNoByp (
    .clk     (clk),
    .reset_n (resetN),
    .bus     (busNoByp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (resetN) begin
      assert (!$isunknown(wrEn)) else $error("[TB] wr_en unknown while out of reset");
    end
  end

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void resetModel();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    model[29]  = 32'h0000_3FFC;
    modelCount = 0;
    modelAck   = 1'b0;
  endfunction

  function automatic logic [31:0] expectRead(input logic [4:0] addr, input bit fwd);
    if (addr == 5'd0) return 32'h0;
    if (fwd && wrEn && (wrAddr == addr)) return wrData;
    return model[addr];
  endfunction

  task automatic test_reset();
    logic [31:0] expA;
    logic [31:0] expB;
    resetN = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetN = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rdAddrA = 5'(i);
      rdAddrB = 5'(31 - i);
      #1;
      expA = (i == 29) ? 32'h0000_3FFC : 32'h0;
      expB = ((31 - i) == 29) ? 32'h0000_3FFC : 32'h0;
      checks++;
      if (busByp.rd_data_a !== expA) begin
        failures++;
        $display("[TB] FAIL reset_read_a addr=%0d got=%h exp=%h", i, busByp.rd_data_a, expA);
      end
      checks++;
      if (busNoByp.rd_data_b !== expB) begin
        failures++;
        $display("[TB] FAIL reset_read_b addr=%0d got=%h exp=%h", 31 - i, busNoByp.rd_data_b, expB);
      end
    end
    checks++;
    if (busByp.wr_ack !== 1'b0 || busByp.write_count !== 16'd0) begin
      failures++;
      $display("[TB] FAIL reset_status ack=%b count=%0d exp ack=0 count=0", busByp.wr_ack, busByp.write_count);
    end
  endtask

  task automatic test_basic_write();
    @(negedge clk);
    wrEn = 1'b1; wrAddr = 5'd8; wrData = 32'hDEAD_BEEF;
    @(negedge clk);
    wrEn = 1'b0; rdAddrA = 5'd8;
    #1;
    checks++;
    if (busNoByp.rd_data_a !== 32'hDEAD_BEEF) begin
      failures++;
      $display("[TB] FAIL basic_read got=%h exp=deadbeef", busNoByp.rd_data_a);
    end
    checks++;
    if (busByp.wr_ack !== 1'b1 || busByp.write_count !== 16'd1) begin
      failures++;
      $display("[TB] FAIL basic_status ack=%b count=%0d exp ack=1 count=1", busByp.wr_ack, busByp.write_count);
    end
    @(negedge clk);
    checks++;
    if (busByp.wr_ack !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_ack_pulse ack=%b exp=0", busByp.wr_ack);
    end
  endtask

  task automatic test_zero_register();
    wrEn = 1'b1; wrAddr = 5'd0; wrData = 32'hFFFF_FFFF;
    rdAddrA = 5'd0; rdAddrB = 5'd0;
    #1;
    checks++;
    if (busByp.rd_data_a !== 32'h0 || busByp.rd_data_b !== 32'h0) begin
      failures++;
      $display("[TB] FAIL zero_no_forward a=%h b=%h exp=0", busByp.rd_data_a, busByp.rd_data_b);
    end
    @(negedge clk);
    wrEn = 1'b0;
    #1;
    checks++;
    if (busNoByp.rd_data_a !== 32'h0 || busNoByp.rd_data_b !== 32'h0) begin
      failures++;
      $display("[TB] FAIL zero_read a=%h b=%h exp=0", busNoByp.rd_data_a, busNoByp.rd_data_b);
    end
    checks++;
    if (busByp.wr_ack !== 1'b0 || busByp.write_count !== 16'd1) begin
      failures++;
      $display("[TB] FAIL zero_status ack=%b count=%0d exp ack=0 count=1", busByp.wr_ack, busByp.write_count);
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    wrEn = 1'b1; wrAddr = 5'd5; wrData = 32'h1234_5678;
    rdAddrA = 5'd5; rdAddrB = 5'd5;
    #1;
    checks++;
    if (busByp.rd_data_a !== 32'h1234_5678 || busByp.rd_data_b !== 32'h1234_5678) begin
      failures++;
      $display("[TB] FAIL bypass_on a=%h b=%h exp=12345678", busByp.rd_data_a, busByp.rd_data_b);
    end
    checks++;
    if (busNoByp.rd_data_a !== 32'h0 || busNoByp.rd_data_b !== 32'h0) begin
      failures++;
      $display("[TB] FAIL bypass_off a=%h b=%h exp=0", busNoByp.rd_data_a, busNoByp.rd_data_b);
    end
    @(negedge clk);
    wrEn = 1'b0;
    #1;
    checks++;
    if (busNoByp.rd_data_a !== 32'h1234_5678 || busNoByp.write_count !== 16'd2) begin
      failures++;
      $display("[TB] FAIL bypass_after a=%h count=%0d exp a=12345678 count=2", busNoByp.rd_data_a, busNoByp.write_count);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    wrEn = 1'b1; wrAddr = 5'd10; wrData = 32'hA5A5_A5A5;
    @(negedge clk);
    wrData = 32'h1111_1111; rdAddrA = 5'd10; rdAddrB = 5'd29;
    #1;
    checks++;
    if (busNoByp.rd_data_a !== 32'hA5A5_A5A5) begin
      failures++;
      $display("[TB] FAIL async_pre got=%h exp=a5a5a5a5", busNoByp.rd_data_a);
    end
    #1;
    resetN = 1'b0;
    #1;
    checks++;
    if (busNoByp.rd_data_a !== 32'h0 || busByp.rd_data_b !== 32'h0000_3FFC) begin
      failures++;
      $display("[TB] FAIL async_immediate r10=%h sp=%h exp r10=0 sp=00003ffc", busNoByp.rd_data_a, busByp.rd_data_b);
    end
    checks++;
    if (busByp.write_count !== 16'd0 || busByp.wr_ack !== 1'b0) begin
      failures++;
      $display("[TB] FAIL async_status count=%0d ack=%b exp count=0 ack=0", busByp.write_count, busByp.wr_ack);
    end
    @(negedge clk);
    wrEn = 1'b0;
    resetN = 1'b1;
    #1;
    checks++;
    if (busByp.rd_data_a !== 32'h0 || busByp.write_count !== 16'd0) begin
      failures++;
      $display("[TB] FAIL async_write_lost r10=%h count=%0d exp r10=0 count=0", busByp.rd_data_a, busByp.write_count);
    end
    resetModel();
  endtask

  task automatic test_random_saturation();
    int  commits;
    int  cycles;
    int  sel;
    bit  commit;
    logic [31:0] expA;
    logic [31:0] expB;
    commits = 0;
    cycles  = 0;
    while (commits < 65540 && cycles < 90000) begin
      @(negedge clk);
      checks++;
      if (busByp.wr_ack !== modelAck || busByp.write_count !== 16'(modelCount)) begin
        failures++;
        $display("[TB] FAIL rand_status cycle=%0d ack=%b count=%0d exp ack=%b count=%0d",
                 cycles, busByp.wr_ack, busByp.write_count, modelAck, modelCount);
      end
      sel    = int'($urandom_range(0, 15));
      wrEn   = (sel != 0);
      wrAddr = (sel == 1) ? 5'd0 : 5'($urandom_range(1, 31));
      wrData = $urandom;
      rdAddrA = ($urandom_range(0, 3) == 0) ? wrAddr : 5'($urandom_range(0, 31));
      rdAddrB = ($urandom_range(0, 3) == 0) ? wrAddr : 5'($urandom_range(0, 31));
      #1;
      expA = expectRead(rdAddrA, 1'b1);
      expB = expectRead(rdAddrB, 1'b1);
      checks++;
      if (busByp.rd_data_a !== expA || busByp.rd_data_b !== expB) begin
        failures++;
        $display("[TB] FAIL rand_read_bypass cycle=%0d a=%h b=%h exp a=%h b=%h",
                 cycles, busByp.rd_data_a, busByp.rd_data_b, expA, expB);
      end
      expA = expectRead(rdAddrA, 1'b0);
      expB = expectRead(rdAddrB, 1'b0);
      checks++;
      if (busNoByp.rd_data_a !== expA || busNoByp.rd_data_b !== expB) begin
        failures++;
        $display("[TB] FAIL rand_read_stored cycle=%0d a=%h b=%h exp a=%h b=%h",
                 cycles, busNoByp.rd_data_a, busNoByp.rd_data_b, expA, expB);
      end
      commit = wrEn && (wrAddr != 5'd0);
      @(posedge clk);
      if (commit) begin
        model[wrAddr] = wrData;
        commits++;
        if (modelCount < 65535) modelCount++;
      end
      modelAck = commit;
      cycles++;
    end
    @(negedge clk);
    wrEn = 1'b0;
    checks++;
    if (commits < 65540) begin
      failures++;
      $display("[TB] FAIL rand_budget commits=%0d exp=65540", commits);
    end
    checks++;
    if (busByp.write_count !== 16'hFFFF || busNoByp.write_count !== 16'hFFFF) begin
      failures++;
      $display("[TB] FAIL saturation count=%h/%h exp=ffff", busByp.write_count, busNoByp.write_count);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    resetN   = 1'b0;
    rdAddrA  = 5'd0;
    rdAddrB  = 5'd0;
    wrEn     = 1'b0;
    wrAddr   = 5'd0;
    wrData   = 32'h0;
    resetModel();
    test_reset();
    test_basic_write();
    test_zero_register();
    test_bypass();
    test_async_reset();
    test_random_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
